// File: rtl/wavelet_rec_frame_ctrl.sv
// wavelet_rec_frame_ctrl: frames one reconstruction stage with zero priming/flush beats,
// tags the stage outputs belonging to the frame and flags upstream gaps and drain stalls.
module wavelet_rec_frame_ctrl #(
   parameter int INTERNAL_WIDTH = 48,
   parameter int LEN_W          = 16,
   parameter int PRIME_BEATS    = 3,
   parameter int FLUSH_BEATS    = 3,
   parameter int STAGE_LAT      = 5,
   parameter int WARMUP         = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [LEN_W-1:0]          frame_len,
   output logic                      busy,
   input  logic                      s_valid,
   input  logic [INTERNAL_WIDTH-1:0] s_data0,
   input  logic [INTERNAL_WIDTH-1:0] s_data1,
   output logic                      s_ready,
   output logic                      stg_valid,
   output logic [INTERNAL_WIDTH-1:0] stg_r0,
   output logic [INTERNAL_WIDTH-1:0] stg_r1,
   input  logic                      stg_dout_valid,
   output logic                      out_keep,
   output logic                      frame_done,
   output logic                      err_gap,
   output logic                      err_timeout
);
   localparam int CW = LEN_W + 2;
   localparam logic [CW-1:0] ONE     = CW'(1);
   localparam logic [CW-1:0] P_LAST  = CW'(PRIME_BEATS - 1);
   localparam logic [CW-1:0] F_LAST  = CW'(FLUSH_BEATS - 1);
   localparam logic [CW-1:0] KEEP_LO = CW'(PRIME_BEATS - WARMUP);
   localparam logic [CW-1:0] TAIL    = CW'(PRIME_BEATS + FLUSH_BEATS - WARMUP - 1);
   localparam logic [CW-1:0] WD_MAX  = CW'(STAGE_LAT + 2);

   typedef enum logic [2:0] {IDLE, PRIME, STREAM, FLUSH, DRAIN, DONE} state_t;

   state_t          state_q;
   logic [CW-1:0]   len_q, cnt_q, beat_q, oidx_q, wd_q;
   logic            busy_q, frame_done_q, err_gap_q, err_timeout_q;
   logic [CW-1:0]   keep_hi;
   logic            streaming;

   // keep_hi is the index of the last output carrying frame data or filter tail
   assign keep_hi    = len_q + TAIL;
   assign streaming  = state_q == STREAM;
   assign s_ready    = streaming && (cnt_q < len_q);
   assign stg_valid  = (state_q == PRIME) || (state_q == FLUSH) || (streaming && s_valid);
   assign stg_r0     = streaming ? s_data0 : '0;
   assign stg_r1     = streaming ? s_data1 : '0;
   assign out_keep   = stg_dout_valid && (state_q != IDLE) && (oidx_q >= KEEP_LO) && (oidx_q <= keep_hi);
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign err_gap    = err_gap_q;
   assign err_timeout = err_timeout_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         len_q         <= '0;
         cnt_q         <= '0;
         beat_q        <= '0;
         oidx_q        <= '0;
         wd_q          <= '0;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
         err_gap_q     <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         if (state_q != IDLE && stg_dout_valid) oidx_q <= oidx_q + ONE;
         case (state_q)
            IDLE: if (start && frame_len != '0) begin
               len_q         <= CW'(frame_len);
               cnt_q         <= '0;
               beat_q        <= '0;
               oidx_q        <= '0;
               err_gap_q     <= 1'b0;
               err_timeout_q <= 1'b0;
               busy_q        <= 1'b1;
               state_q       <= PRIME;
            end
            PRIME: begin
               beat_q <= beat_q + ONE;
               if (beat_q == P_LAST) begin
                  beat_q  <= '0;
                  state_q <= STREAM;
               end
            end
            STREAM: if (s_valid) begin
               cnt_q <= cnt_q + ONE;
               if (cnt_q + ONE == len_q) state_q <= FLUSH;
            end else err_gap_q <= 1'b1;
            FLUSH: begin
               beat_q <= beat_q + ONE;
               if (beat_q == F_LAST) begin
                  beat_q  <= '0;
                  wd_q    <= '0;
                  state_q <= DRAIN;
               end
            end
            DRAIN: if (stg_dout_valid) begin
               wd_q <= '0;
               if (oidx_q == keep_hi) begin
                  frame_done_q <= 1'b1;
                  state_q      <= DONE;
               end
            end else begin
               wd_q <= wd_q + ONE;
               if (wd_q + ONE == WD_MAX) begin
                  err_timeout_q <= 1'b1;
                  frame_done_q  <= 1'b1;
                  state_q       <= DONE;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/wavelet_rec_frame_ctrl.md
Name: wavelet_rec_frame_ctrl

Overview:
- Frame sequencer for one wavelet reconstruction stage, e.g. the L3 r3→r2 stage: 2 coefficients in per beat, 4 out, 8-tap filter, 3-beat history, 2-beat warm-up, valid-in→valid-out 5 cycles, no backpressure.
- Per frame: clears stage history with zero priming beats, streams N upstream coefficient pairs, then appends zero flush beats so the filter tail emerges.
- Tags which stage outputs belong to the frame, signals completion and flags upstream gaps.

Parameters:
INTERNAL_WIDTH, 48, coefficient data width
LEN_W, 16, width of frame_len and counters
PRIME_BEATS, 3, zero beats before data (= stage history depth)
FLUSH_BEATS, 3, zero beats after data (= taps/2 - 1)
STAGE_LAT, 5, stage valid-in→valid-out latency
WARMUP, 2, leading contiguous stage beats that produce no output

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin frame; sampled only in IDLE
frame_len  in  LEN_W  pairs in frame; latched on accepted start
busy  out  1  high in any state except IDLE
s_valid  in  1  upstream pair valid
s_data0  in  INTERNAL_WIDTH  upstream older coefficient
s_data1  in  INTERNAL_WIDTH  upstream newer coefficient
s_ready  out  1  controller accepts pair this cycle
stg_valid  out  1  to stage din_valid
stg_r0  out  INTERNAL_WIDTH  to stage r3_0
stg_r1  out  INTERNAL_WIDTH  to stage r3_1
stg_dout_valid  in  1  from stage dout_valid
out_keep  out  1  current stage output belongs to frame
frame_done  out  1  one-cycle pulse at frame end
err_gap  out  1  sticky: s_valid low during STREAM
err_timeout  out  1  sticky: drain watchdog expired

Behaviour:
- Reset: state IDLE, all counters 0; busy, s_ready, stg_valid, out_keep, frame_done, err_gap, err_timeout = 0.
- Async reset mid-frame aborts immediately; no frame_done is produced.
- Upstream handshake: transfer when s_valid && s_ready.
- s_ready is combinational: (state==STREAM) && (data count < len).
- stg_valid is combinational:
  - 1 in PRIME and FLUSH.
  - s_valid in STREAM.
  - 0 otherwise.
- stg_r0/stg_r1 are combinational: s_data0/s_data1 in STREAM, else 0.
- FSM:
  - IDLE: on start with frame_len != 0, latch len, clear err_gap and err_timeout, go to PRIME.
  - IDLE: start with frame_len == 0 is ignored, with no pulse.
  - PRIME: PRIME_BEATS cycles, then STREAM.
  - STREAM: count each transfer. After transfer number len, go to FLUSH.
  - STREAM: a cycle with s_valid=0 sets err_gap. State holds, stg_valid=0, and the stage loses warm-up.
  - FLUSH: FLUSH_BEATS cycles, then DRAIN.
  - DRAIN: wait for the last kept output, then go to DONE.
  - DRAIN watchdog: counts cycles since the last stg_dout_valid, restarting on entry. If it reaches STAGE_LAT+2, set err_timeout and go to DONE.
  - DONE: frame_done=1 for one cycle, then IDLE. busy is low in the following cycle.
- Output tagging:
  - Output index o_idx counts stg_dout_valid pulses from 0 at frame start.
  - Contiguous stage beats total T = PRIME_BEATS+len+FLUSH_BEATS, giving T-WARMUP outputs.
  - The first PRIME_BEATS-WARMUP outputs (=1) carry prime-only data and are discarded.
  - out_keep = stg_dout_valid && o_idx in [PRIME_BEATS-WARMUP, T-WARMUP-1], i.e. len+FLUSH_BEATS kept outputs.
  - DRAIN completes in the cycle after o_idx T-WARMUP-1 is seen.
- Any stg_dout_valid in IDLE has out_keep=0 and does not touch counters.
- start while busy is ignored.
- frame_len==1: the frame still produces 4 kept outputs.
- Counters are LEN_W+2 bits, so len=2^LEN_W-1 does not wrap.

Test Plan:
- Reset mid-STREAM (len=8, after 3 transfers) → all outputs 0 next edge. A new start with len=2 then runs a clean frame: 5 kept outputs, no error flags.
- len=4, start at cycle 0, s_valid held high, stage attached → stg_valid high cycles 1–10 and s_ready high cycles 4–7; stage dout_valid cycles 8–15; out_keep cycles 9–15 (7 outputs); frame_done at cycle 16.
- len=1 with pair (1.0,0) in Q23 and Haar-like coefficients → 4 kept outputs whose values match the reference model; frame_done, no errors.
- len=6 with s_valid dropped for 2 cycles after 2 transfers → err_gap=1. Watchdog fires, setting err_timeout=1, and frame_done pulses; with contiguous stage outputs the frame completes by count instead.
- start pulsed every cycle, len=3 → exactly one frame per IDLE entry; frame_done pulse count equals frames started; busy low exactly one cycle between frames.
- start with frame_len=0 → remains IDLE, busy=0, no stg_valid, no frame_done.
